// File: rtl/led_rate_pkg.sv
// Shared constants and types for LED blink-rate generation and decoding.
// Half-periods are in 25 kHz clock cycles.
package led_rate_pkg;

  localparam int unsigned c_DEF_CNT_100HZ = 125;
  localparam int unsigned c_DEF_CNT_50HZ  = 250;
  localparam int unsigned c_DEF_CNT_10HZ  = 1250;
  localparam int unsigned c_DEF_CNT_1HZ   = 12500;
  localparam int unsigned c_DEF_TOL_SHIFT = 3;
  localparam int unsigned c_DEF_TIMEOUT   = 25000;

  localparam int unsigned c_CNT_W = 16;

  typedef enum logic [1:0] {
    RATE_100HZ = 2'b00,
    RATE_50HZ  = 2'b01,
    RATE_10HZ  = 2'b10,
    RATE_1HZ   = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_LOCKED
  } state_e;

  typedef struct packed {
    logic  valid;
    rate_e rate;
  } class_t;

  // Written as iv + tol >= nom so a short interval never underflows.
  function automatic logic in_tol(input logic [c_CNT_W-1:0] i_iv,
                                  input int unsigned i_nom,
                                  input int unsigned i_shift);
    int unsigned w_iv;
    int unsigned w_tol;
    w_iv  = {16'b0, i_iv};
    w_tol = i_nom >> i_shift;
    return ((w_iv + w_tol) >= i_nom) && (w_iv <= (i_nom + w_tol));
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by an any-edge
// detector; the edge pulse is registered and appears 3 clocks after the input moves.
module sync_edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_edge;

  // NOTE: non-blocking assignments keep each flop sampling the previous stage's
  // old value; blocking here would collapse the chain into a single flop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_edge <= r_sync ^ r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_edge  = r_edge;

endmodule

// File: rtl/led_rate_decoder.sv
// Classifies the half-period of an LED drive square wave into one of four
// blink rates, locking after two consecutive matching intervals.
module led_rate_decoder
  import led_rate_pkg::*;
#(
  parameter int unsigned c_CNT_100HZ = c_DEF_CNT_100HZ,
  parameter int unsigned c_CNT_50HZ  = c_DEF_CNT_50HZ,
  parameter int unsigned c_CNT_10HZ  = c_DEF_CNT_10HZ,
  parameter int unsigned c_CNT_1HZ   = c_DEF_CNT_1HZ,
  parameter int unsigned c_TOL_SHIFT = c_DEF_TOL_SHIFT,
  parameter int unsigned c_TIMEOUT   = c_DEF_TIMEOUT
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_signal,
  output logic [1:0] o_rate,
  output logic       o_locked,
  output logic       o_update,
  output logic       o_timeout
);

  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_TIMEOUT);

  logic               w_level_unused;
  logic               w_edge;
  logic [c_CNT_W-1:0] w_interval;
  logic               w_expired;
  class_t             w_class;

  state_e             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  rate_e              r_cand;
  rate_e              r_rate;
  logic               r_locked;
  logic               r_update;
  logic               r_timeout;

  function automatic class_t classify(input logic [c_CNT_W-1:0] i_iv);
    class_t w_c;
    w_c.valid = 1'b1;
    w_c.rate  = RATE_100HZ;
    if (in_tol(i_iv, c_CNT_100HZ, c_TOL_SHIFT))     w_c.rate = RATE_100HZ;
    else if (in_tol(i_iv, c_CNT_50HZ, c_TOL_SHIFT)) w_c.rate = RATE_50HZ;
    else if (in_tol(i_iv, c_CNT_10HZ, c_TOL_SHIFT)) w_c.rate = RATE_10HZ;
    else if (in_tol(i_iv, c_CNT_1HZ, c_TOL_SHIFT))  w_c.rate = RATE_1HZ;
    else                                            w_c.valid = 1'b0;
    return w_c;
  endfunction

  sync_edge_detect u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_signal),
    .o_level (w_level_unused),
    .o_edge  (w_edge)
  );

  // The counter holds edge-to-edge distance minus one when the next edge lands.
  assign w_interval = r_cnt + c_CNT_W'(1);
  assign w_class    = classify(w_interval);
  assign w_expired  = (r_cnt == c_CNT_MAX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cand    <= RATE_100HZ;
      r_rate    <= RATE_100HZ;
      r_locked  <= 1'b0;
      r_update  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_update  <= 1'b0;
      r_timeout <= 1'b0;

      if (w_edge)          r_cnt <= '0;
      else if (!w_expired) r_cnt <= r_cnt + c_CNT_W'(1);

      // An edge always wins over an expiring counter in the same cycle.
      case (r_state)
        ST_IDLE: begin
          if (w_edge) r_state <= ST_ARMED;
        end

        ST_ARMED: begin
          if (w_edge) begin
            if (w_class.valid) begin
              r_state <= ST_MEASURE;
              r_cand  <= w_class.rate;
            end
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end
        end

        ST_MEASURE: begin
          if (w_edge) begin
            if (!w_class.valid) begin
              r_state <= ST_ARMED;
            end else if (w_class.rate == r_cand) begin
              r_state  <= ST_LOCKED;
              r_rate   <= r_cand;
              r_locked <= 1'b1;
              r_update <= 1'b1;
            end else begin
              r_cand <= w_class.rate;
            end
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end
        end

        ST_LOCKED: begin
          if (w_edge) begin
            if (!w_class.valid) begin
              r_state  <= ST_ARMED;
              r_locked <= 1'b0;
            end else if (w_class.rate != r_rate) begin
              r_state  <= ST_MEASURE;
              r_cand   <= w_class.rate;
              r_locked <= 1'b0;
            end
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_locked  <= 1'b0;
            r_timeout <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rate    = r_rate;
  assign o_locked  = r_locked;
  assign o_update  = r_update;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_led_rate_decoder.sv
// Directed bench for led_rate_decoder: lock at each rate, tolerance edges,
// rate change, timeout, edge-versus-timeout priority and mid-measurement reset.
module tb_led_rate_decoder;

  logic       clk;
  logic       rst;
  logic       sig;
  logic [1:0] o_rate;
  logic       o_locked;
  logic       o_update;
  logic       o_timeout;

  int n_vec;
  int n_err;
  int n_upd;
  int n_to;
  int base_upd;
  int base_to;

  led_rate_decoder dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_signal  (sig),
    .o_rate    (o_rate),
    .o_locked  (o_locked),
    .o_update  (o_update),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample the pre-update output values at each rising edge.
  always @(posedge clk) begin
    if (o_update)  n_upd <= n_upd + 1;
    if (o_timeout) n_to  <= n_to + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait n rising edges, then toggle the input just after the edge.
  task automatic tog(input int n);
    repeat (n) @(posedge clk);
    #1 sig = ~sig;
  endtask

  // Five edges cover the 3-clock detect latency plus the registered outputs.
  task automatic settle();
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 rst = 1'b1;
    sig = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_upd = 0; n_to = 0;
    rst = 1'b1; sig = 1'b0;

    // Reset state
    do_reset(2);
    chk("rst_rate", 32'(o_rate), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_update", 32'(o_update), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);

    // 100 Hz: locks on third edge, then holds for 20 more
    base_upd = n_upd;
    tog(1); settle();
    tog(120); settle();
    chk("100hz_edge2_unlocked", 32'(o_locked), 32'd0);
    tog(120); settle();
    chk("100hz_locked", 32'(o_locked), 32'd1);
    chk("100hz_rate", 32'(o_rate), 32'd0);
    chk("100hz_update", 32'(n_upd - base_upd), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tog(120); settle();
      chk("100hz_hold", 32'(o_locked), 32'd1);
    end
    chk("100hz_no_extra_update", 32'(n_upd - base_upd), 32'd1);

    // 1 Hz lock, then switch to 10 Hz
    do_reset(2);
    base_upd = n_upd;
    tog(1); settle();
    tog(12495); settle();
    tog(12495); settle();
    chk("1hz_locked", 32'(o_locked), 32'd1);
    chk("1hz_rate", 32'(o_rate), 32'd3);
    chk("1hz_update", 32'(n_upd - base_upd), 32'd1);
    base_upd = n_upd;
    tog(1245); settle();
    chk("switch_unlocked", 32'(o_locked), 32'd0);
    chk("switch_rate_held", 32'(o_rate), 32'd3);
    tog(1245); settle();
    chk("10hz_locked", 32'(o_locked), 32'd1);
    chk("10hz_rate", 32'(o_rate), 32'd2);
    chk("10hz_one_update", 32'(n_upd - base_upd), 32'd1);

    // Tolerance: 140 is the top of the 100 Hz window, 141 matches nothing
    do_reset(2);
    tog(1); settle();
    tog(135); settle();
    tog(135); settle();
    chk("iv140_locked", 32'(o_locked), 32'd1);
    chk("iv140_rate", 32'(o_rate), 32'd0);
    do_reset(2);
    base_upd = n_upd;
    tog(1); settle();
    for (int i = 0; i < 4; i++) begin
      tog(136); settle();
    end
    chk("iv141_unlocked", 32'(o_locked), 32'd0);
    chk("iv141_no_update", 32'(n_upd - base_upd), 32'd0);

    // 50 Hz lock; edge exactly at counter saturation; relock; then timeout
    do_reset(2);
    base_upd = n_upd;
    tog(1); settle();
    tog(245); settle();
    tog(245); settle();
    chk("50hz_locked", 32'(o_locked), 32'd1);
    chk("50hz_rate", 32'(o_rate), 32'd1);
    base_to = n_to;
    tog(24996); settle();
    chk("coinc_no_timeout", 32'(n_to - base_to), 32'd0);
    chk("coinc_invalid_unlocked", 32'(o_locked), 32'd0);
    chk("coinc_rate_held", 32'(o_rate), 32'd1);
    base_upd = n_upd;
    tog(245); settle();
    tog(245); settle();
    chk("50hz_relocked", 32'(o_locked), 32'd1);
    chk("50hz_relock_update", 32'(n_upd - base_upd), 32'd1);
    repeat (24999) @(negedge clk);
    chk("to_not_early", 32'(n_to - base_to), 32'd0);
    chk("to_still_locked", 32'(o_locked), 32'd1);
    @(negedge clk);
    chk("to_pulse", 32'(o_timeout), 32'd1);
    chk("to_unlocked", 32'(o_locked), 32'd0);
    repeat (100) @(negedge clk);
    chk("to_once", 32'(n_to - base_to), 32'd1);
    chk("to_rate_held", 32'(o_rate), 32'd1);
    chk("to_stays_unlocked", 32'(o_locked), 32'd0);

    // Reset during MEASURE discards progress
    do_reset(2);
    tog(1); settle();
    tog(245); settle();
    tog(245); settle();
    chk("pre_rst_locked", 32'(o_locked), 32'd1);
    tog(120); settle();
    chk("measure_unlocked", 32'(o_locked), 32'd0);
    chk("measure_rate_held", 32'(o_rate), 32'd1);
    do_reset(1);
    chk("midrst_rate", 32'(o_rate), 32'd0);
    chk("midrst_locked", 32'(o_locked), 32'd0);
    chk("midrst_update", 32'(o_update), 32'd0);
    chk("midrst_timeout", 32'(o_timeout), 32'd0);
    base_upd = n_upd;
    tog(1); settle();
    tog(120); settle();
    chk("midrst_edge2_unlocked", 32'(o_locked), 32'd0);
    tog(120); settle();
    chk("midrst_relocked", 32'(o_locked), 32'd1);
    chk("midrst_relock_rate", 32'(o_rate), 32'd0);
    chk("midrst_relock_update", 32'(n_upd - base_upd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
